// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART with a 4-byte register window.
// Registers: 0 DATA, 1 STATUS, 2 DIVLO, 3 DIVHI.
// Optional interrupt output is enabled by defining IO_UART_IRQ_EN.
`ifndef ADDR_RAM
`define ADDR_RAM 16'h8000
`endif

module io_uart #(
  parameter logic [15:0] BASE        = 16'h0000,
  parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  io_di,
  output logic [7:0]  io_do,
  input  logic        we,
  input  logic        re,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic        sel;
  logic [1:0]  idx;
  logic        wr_data, rd_data, wr_status, rd_status, wr_divlo, wr_divhi;
  logic [15:0] div_q, period, half, half_m1;

  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_busy, tx_line;

  logic        rx_s1, rx_s2, rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_data;
  logic        rx_valid, rx_overrun, rx_frame_err;
  logic        irq_en;

  assign sel       = (addr < `ADDR_RAM) && (addr[15:2] == BASE[15:2]);
  assign idx       = addr[1:0];
  assign wr_data   = sel && we && (idx == 2'd0);
  assign rd_data   = sel && re && (idx == 2'd0);
  assign wr_status = sel && we && (idx == 2'd1);
  assign rd_status = sel && re && (idx == 2'd1);
  assign wr_divlo  = sel && we && (idx == 2'd2);
  assign wr_divhi  = sel && we && (idx == 2'd3);

  // Bit period is sampled when each bit starts, so a divisor write lands at the next bit boundary.
  assign period  = (div_q == 16'd0) ? 16'd1 : div_q;
  assign half    = period >> 1;
  // One clock of the half-bit wait is absorbed by the edge-detect register.
  assign half_m1 = (half == 16'd0) ? 16'd0 : half - 16'd1;

  assign uart_tx = tx_line;

  // Baud divisor register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_DEFAULT;
    end else begin
      if (wr_divlo) div_q[7:0]  <= io_di;
      if (wr_divhi) div_q[15:8] <= io_di;
    end
  end

  // Transmit FSM: start bit, 8 data bits LSB first, stop bit; writes while busy are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_busy  <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          if (wr_data) begin
            tx_state <= ST_START;
            tx_busy  <= 1'b1;
            tx_line  <= 1'b0;
            tx_shift <= io_di;
            tx_cnt   <= period - 16'd1;
          end
        end
        ST_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= ST_DATA;
            tx_line  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= 3'd0;
            tx_cnt   <= period - 16'd1;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= period - 16'd1;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              tx_line  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_line  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= ST_IDLE;
            tx_busy  <= 1'b0;
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

  // Two-flop synchroniser plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive FSM and RX flags; CPU read-clears are applied first so a same-edge delivery or error wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= ST_IDLE;
      rx_cnt       <= 16'd0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'd0;
      rx_data      <= 8'd0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (rd_data) rx_valid <= 1'b0;
      if (rd_status) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      case (rx_state)
        ST_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= ST_START;
            rx_cnt   <= half_m1;
          end
        end
        ST_START: begin
          if (rx_cnt == 16'd0) begin
            if (rx_s2) begin
              rx_state <= ST_IDLE;
            end else begin
              rx_state <= ST_DATA;
              rx_bit   <= 3'd0;
              rx_cnt   <= period - 16'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == 16'd0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= period - 16'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
        default: begin
          if (rx_cnt == 16'd0) begin
            rx_state <= ST_IDLE;
            if (!rx_s2) begin
              rx_frame_err <= 1'b1;
            end else if (rx_valid && !rd_data) begin
              rx_overrun <= 1'b1;
            end else begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - 16'd1;
          end
        end
      endcase
    end
  end

`ifdef IO_UART_IRQ_EN
  // Interrupt enable and registered level interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_status) irq_en <= io_di[4];
      irq <= irq_en & (rx_valid | ~tx_busy);
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  // Register read mux; zero when the window is not addressed.
  always_comb begin
    io_do = 8'h00;
    if (sel) begin
      case (idx)
        2'd0:    io_do = rx_data;
        2'd1:    io_do = {3'b000, irq_en, rx_frame_err, rx_overrun, rx_valid, tx_busy};
        2'd2:    io_do = div_q[7:0];
        default: io_do = div_q[15:8];
      endcase
    end
  end

endmodule
